// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
//   Bundles every non-clock/reset signal of the ID/EX stage.
//   master : the environment (decode, hazard/flush source, later stages)
//   slave  : the ID/EX stage itself
//   ID side      : id_valid, id_rs/rt_data, id_rs/rt/rd_addr, id_op_code,
//                  id_shamt, id_reg_write, id_mem_read, flush
//   Forward side : exm_reg_write, exm_rd_addr, exm_result,
//                  wb_reg_write, wb_rd_addr, wb_result
//   EX side      : stall_id, ex_valid, alu_reg1, alu_reg2, alu_op_code,
//                  alu_shamt, ex_rd_addr, ex_reg_write, ex_mem_read
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [ADDR_W-1:0] id_rs_addr;
  logic [ADDR_W-1:0] id_rt_addr;
  logic [ADDR_W-1:0] id_rd_addr;
  logic [4:0]        id_op_code;
  logic [4:0]        id_shamt;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              exm_reg_write;
  logic [ADDR_W-1:0] exm_rd_addr;
  logic [DATA_W-1:0] exm_result;
  logic              wb_reg_write;
  logic [ADDR_W-1:0] wb_rd_addr;
  logic [DATA_W-1:0] wb_result;
  logic              stall_id;
  logic              ex_valid;
  logic [DATA_W-1:0] alu_reg1;
  logic [DATA_W-1:0] alu_reg2;
  logic [4:0]        alu_op_code;
  logic [4:0]        alu_shamt;
  logic [ADDR_W-1:0] ex_rd_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_rs_addr, id_rt_addr, id_rd_addr,
           id_op_code, id_shamt, id_reg_write, id_mem_read, flush,
           exm_reg_write, exm_rd_addr, exm_result,
           wb_reg_write, wb_rd_addr, wb_result,
    input  stall_id, ex_valid, alu_reg1, alu_reg2, alu_op_code, alu_shamt,
           ex_rd_addr, ex_reg_write, ex_mem_read
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_rs_addr, id_rt_addr, id_rd_addr,
           id_op_code, id_shamt, id_reg_write, id_mem_read, flush,
           exm_reg_write, exm_rd_addr, exm_result,
           wb_reg_write, wb_rd_addr, wb_result,
    output stall_id, ex_valid, alu_reg1, alu_reg2, alu_op_code, alu_shamt,
           ex_rd_addr, ex_reg_write, ex_mem_read
  );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with load-use hazard detection and operand
//   forwarding from EX/MEM and MEM/WB, feeding the execute ALU.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : id_ex_stage_if.slave (ID inputs, forwarding inputs, EX outputs)
//   stall_id and alu_reg1/alu_reg2 are combinational; every other output
//   comes straight from the pipeline register.
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int         DATA_W = 32,
  parameter int         ADDR_W = 5,
  parameter logic [4:0] NOP_OP = 5'd12
) (
  input logic           clk,
  input logic           rst_n,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [4:0]        op_code;
    logic [4:0]        shamt;
    logic              reg_write;
    logic              mem_read;
  } ex_regs_t;

  // A bubble zeroes every field except the op_code, which becomes the ALU nop.
  // Zero register addresses guarantee a bubble never picks up a forward.
  function automatic ex_regs_t bubble_f();
    ex_regs_t b;
    b         = '0;
    b.op_code = NOP_OP;
    return b;
  endfunction

  // EX/MEM has the youngest result, so it wins over MEM/WB; r0 never forwards.
  function automatic logic [DATA_W-1:0] fwd_f(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] raw,
    input logic              exm_we,
    input logic [ADDR_W-1:0] exm_rd,
    input logic [DATA_W-1:0] exm_res,
    input logic              wb_we,
    input logic [ADDR_W-1:0] wb_rd,
    input logic [DATA_W-1:0] wb_res
  );
    logic [DATA_W-1:0] val;
    if (exm_we && (exm_rd != {ADDR_W{1'b0}}) && (exm_rd == addr)) begin
      val = exm_res;
    end else if (wb_we && (wb_rd != {ADDR_W{1'b0}}) && (wb_rd == addr)) begin
      val = wb_res;
    end else begin
      val = raw;
    end
    return val;
  endfunction

  ex_regs_t          ex_r;
  ex_regs_t          ex_nxt_s;
  logic              stall_s;
  logic [DATA_W-1:0] reg1_s;
  logic [DATA_W-1:0] reg2_s;

  // Load-use hazard: the load in EX cannot forward in time for the ID consumer.
  always_comb begin
    stall_s = bus.id_valid & ex_r.valid & ex_r.mem_read &
              (ex_r.rd_addr != {ADDR_W{1'b0}}) &
              ((ex_r.rd_addr == bus.id_rs_addr) | (ex_r.rd_addr == bus.id_rt_addr));
  end

  // Next pipeline contents: flush and stall both squash, else capture ID.
  always_comb begin
    ex_nxt_s = bubble_f();
    if (bus.flush || stall_s || !bus.id_valid) begin
      ex_nxt_s = bubble_f();
    end else begin
      ex_nxt_s.valid     = 1'b1;
      ex_nxt_s.rs_data   = bus.id_rs_data;
      ex_nxt_s.rt_data   = bus.id_rt_data;
      ex_nxt_s.rs_addr   = bus.id_rs_addr;
      ex_nxt_s.rt_addr   = bus.id_rt_addr;
      ex_nxt_s.rd_addr   = bus.id_rd_addr;
      ex_nxt_s.op_code   = bus.id_op_code;
      ex_nxt_s.shamt     = bus.id_shamt;
      ex_nxt_s.reg_write = bus.id_reg_write;
      ex_nxt_s.mem_read  = bus.id_mem_read;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r <= bubble_f();
    end else begin
      ex_r <= ex_nxt_s;
    end
  end

  // Operand forwarding on the registered source addresses.
  always_comb begin
    reg1_s = fwd_f(ex_r.rs_addr, ex_r.rs_data,
                   bus.exm_reg_write, bus.exm_rd_addr, bus.exm_result,
                   bus.wb_reg_write, bus.wb_rd_addr, bus.wb_result);
    reg2_s = fwd_f(ex_r.rt_addr, ex_r.rt_data,
                   bus.exm_reg_write, bus.exm_rd_addr, bus.exm_result,
                   bus.wb_reg_write, bus.wb_rd_addr, bus.wb_result);
  end

  assign bus.stall_id     = stall_s;
  assign bus.ex_valid     = ex_r.valid;
  assign bus.alu_reg1     = reg1_s;
  assign bus.alu_reg2     = reg2_s;
  assign bus.alu_op_code  = ex_r.op_code;
  assign bus.alu_shamt    = ex_r.shamt;
  assign bus.ex_rd_addr   = ex_r.rd_addr;
  assign bus.ex_reg_write = ex_r.reg_write;
  assign bus.ex_mem_read  = ex_r.mem_read;

endmodule
